// File: rtl/comparator_threshold_monitor.sv
// Streaming threshold monitor: registers lt/eq/gt of each sample against a programmable
// threshold, then debounces the result into an alarm with hysteresis. Optional min/max: THRESHOLD_MONITOR_MINMAX_EN.
module comparator_threshold_monitor #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned PERSIST_WIDTH = 4
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  input  logic                     Clear_In,
  input  logic                     Threshold_Load_In,
  input  logic [DATA_WIDTH-1:0]    Threshold_In,
  input  logic [PERSIST_WIDTH-1:0] Persist_Count_In,
  input  logic                     Sample_Valid_In,
  input  logic [DATA_WIDTH-1:0]    Sample_Data_In,
  output logic                     Sample_Ready_Out,
  output logic                     Alarm_Out,
  output logic                     Alarm_Rise_Out,
  output logic                     Alarm_Fall_Out,
  output logic [DATA_WIDTH-1:0]    Max_Out,
  output logic [DATA_WIDTH-1:0]    Min_Out,
  output logic [15:0]              Sample_Count_Out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND_SET,
    ST_ALARM,
    ST_PEND_CLR
  } state_t;

  logic [DATA_WIDTH-1:0]    r_thr;
  logic [PERSIST_WIDTH-1:0] r_persist;
  logic                     r_s1_valid;
  logic [2:0]               r_s1_flags;   // {lt, eq, gt}
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PERSIST_WIDTH-1:0] r_cnt;
  logic [PERSIST_WIDTH-1:0] w_cnt_nxt;
  logic [PERSIST_WIDTH-1:0] w_cnt_inc;
  logic [PERSIST_WIDTH-1:0] w_persist_eff;
  logic                     r_rise;
  logic                     r_fall;
  logic                     w_rise_nxt;
  logic                     w_fall_nxt;
  logic                     w_alarm_cur;
  logic                     w_alarm_nxt;
  logic                     w_accept;
  logic                     w_lt;
  logic                     w_gt;
  logic [15:0]              r_count;

  assign Sample_Ready_Out = ~Clear_In & ~Threshold_Load_In;
  assign w_accept         = Sample_Valid_In & Sample_Ready_Out;
  assign w_persist_eff    = (r_persist == '0) ? PERSIST_WIDTH'(1) : r_persist;
  assign w_lt             = (r_s1_flags == 3'b100);
  assign w_gt             = (r_s1_flags == 3'b001);

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_thr     <= '1;
      r_persist <= PERSIST_WIDTH'(1);
    end else if (!Clear_In && Threshold_Load_In) begin
      r_thr     <= Threshold_In;
      r_persist <= Persist_Count_In;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_s1_valid <= 1'b0;
      r_s1_flags <= '0;
    end else if (Clear_In) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_flags <= {Sample_Data_In < r_thr, Sample_Data_In == r_thr, Sample_Data_In > r_thr};
      end
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cnt_inc   = r_cnt + PERSIST_WIDTH'(1);
    if (r_s1_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_gt) begin
            if (w_persist_eff == PERSIST_WIDTH'(1)) begin
              w_state_nxt = ST_ALARM;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_PEND_SET;
              w_cnt_nxt   = PERSIST_WIDTH'(1);
            end
          end
        end
        ST_PEND_SET: begin
          if (w_gt) begin
            if (w_cnt_inc >= w_persist_eff) begin
              w_state_nxt = ST_ALARM;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else if (w_lt) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_ALARM: begin
          if (w_lt) begin
            if (w_persist_eff == PERSIST_WIDTH'(1)) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_PEND_CLR;
              w_cnt_nxt   = PERSIST_WIDTH'(1);
            end
          end
        end
        ST_PEND_CLR: begin
          if (w_lt) begin
            if (w_cnt_inc >= w_persist_eff) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else if (w_gt) begin
            w_state_nxt = ST_ALARM;
            w_cnt_nxt   = '0;
          end
        end
      endcase
    end
    // A load cancels any pending transition after the in-flight sample is evaluated,
    // so the alarm level itself is never changed by a load.
    if (Threshold_Load_In) begin
      w_cnt_nxt = '0;
      if (w_state_nxt == ST_PEND_SET) w_state_nxt = ST_IDLE;
      if (w_state_nxt == ST_PEND_CLR) w_state_nxt = ST_ALARM;
    end
    if (Clear_In) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
    w_alarm_cur = (r_state == ST_ALARM) || (r_state == ST_PEND_CLR);
    w_alarm_nxt = (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_PEND_CLR);
    w_rise_nxt  = ~w_alarm_cur & w_alarm_nxt & ~Clear_In;
    w_fall_nxt  = w_alarm_cur & ~w_alarm_nxt & ~Clear_In;
  end

  assign Alarm_Out      = w_alarm_cur;
  assign Alarm_Rise_Out = r_rise;
  assign Alarm_Fall_Out = r_fall;

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_count <= '0;
    end else if (Clear_In) begin
      r_count <= '0;
    end else if (r_s1_valid && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign Sample_Count_Out = r_count;

`ifdef THRESHOLD_MONITOR_MINMAX_EN
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [DATA_WIDTH-1:0] r_max;
  logic [DATA_WIDTH-1:0] r_min;

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_s1_data <= '0;
    end else if (!Clear_In && w_accept) begin
      r_s1_data <= Sample_Data_In;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_max <= '0;
      r_min <= '1;
    end else if (Clear_In) begin
      r_max <= '0;
      r_min <= '1;
    end else if (r_s1_valid) begin
      if (r_s1_data > r_max) r_max <= r_s1_data;
      if (r_s1_data < r_min) r_min <= r_s1_data;
    end
  end

  assign Max_Out = r_max;
  assign Min_Out = r_min;
`else
  assign Max_Out = '0;
  assign Min_Out = '1;
`endif

endmodule
